jtag_master: RTL and testbench

Command-driven JTAG TAP controller master that generates TCK/TMS/TDI for the on-board TAP (OnboardTop JB_* pins) and captures TDO. It sits directly upstream of the TAP. It converts "reset / shift IR / shift DR / idle" commands from on-chip control logic into correct TMS walks and LSB-first bit streams. Each command starts and ends in Run-Test/Idle, and the captured TDO word is returned as a response.

---
 rtl/jtag_master.sv | 207 ++++++++++++++++++++
 tb/tb_jtag_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : jtag_master
// Description : Command-driven JTAG TAP master. Turns reset / shift-IR /
//               shift-DR / idle commands into TMS walks and LSB-first TDI
//               streams, captures TDO and returns it as a response.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_master #(
    parameter int IR_LEN  = 4,
    parameter int DR_MAX  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_len,
    input  logic [DR_MAX-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DR_MAX-1:0] rsp_data,
    output logic              rsp_err,
    output logic              TCK,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO
);

    localparam int            IW       = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;
    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [4:0]    LEN_MAX  = 5'(DR_MAX);
    localparam logic [7:0]    IRL      = 8'(IR_LEN);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic          tms;
        logic          shift;
        logic [IW-1:0] sidx;
    } tick_t;

    // Number of TCK ticks in one phase (the unsynced prefix is its own phase).
    function automatic logic [7:0] tick_count(input logic in_prefix, input logic [1:0] op,
                                              input logic [4:0] len);
        logic [7:0] n;
        if (in_prefix || op == OP_RESET) n = 8'd6;
        else if (op == OP_IR)            n = IRL + 8'd6;
        else if (op == OP_DR)            n = {3'b000, len} + 8'd5;
        else                             n = {3'b000, len};
        return n;
    endfunction

    // TMS value and shift position of tick j within a phase.
    function automatic tick_t tick_info(input logic in_prefix, input logic [1:0] op,
                                        input logic [4:0] len, input logic [7:0] j);
        tick_t      t;
        logic [7:0] l8;
        logic [7:0] s;
        t  = '0;
        s  = 8'd0;
        l8 = {3'b000, len};
        if (in_prefix || op == OP_RESET) begin
            t.tms = (j < 8'd5);
        end else if (op == OP_IR) begin
            if (j < 8'd2)             t.tms = 1'b1;
            else if (j < 8'd4)        t.tms = 1'b0;
            else if (j < 8'd4 + IRL) begin
                t.shift = 1'b1;
                t.tms   = (j == 8'd3 + IRL);
                s       = j - 8'd4;
            end else                  t.tms = (j == 8'd4 + IRL);
        end else if (op == OP_DR) begin
            if (j == 8'd0)            t.tms = 1'b1;
            else if (j < 8'd3)        t.tms = 1'b0;
            else if (j < 8'd3 + l8) begin
                t.shift = 1'b1;
                t.tms   = (j == 8'd2 + l8);
                s       = j - 8'd3;
            end else                  t.tms = (j == 8'd3 + l8);
        end
        t.sidx = s[IW-1:0];
        return t;
    endfunction

    state_t            state;
    logic [1:0]        op_q;
    logic [4:0]        len_q;
    logic [DR_MAX-1:0] data_q;
    logic [DR_MAX-1:0] cap;
    logic [7:0]        tick;
    logic [DW-1:0]     div;
    logic              starting;
    logic              synced;

    tick_t      cur;
    tick_t      nxt;
    logic       cur_last;
    logic       nxt_prefix;
    logic [7:0] nxt_tick;
    logic       cur_tdi;
    logic       nxt_tdi;
    logic       len_bad;

    always_comb begin
        cur_last   = (tick == tick_count(state == PREFIX, op_q, len_q) - 8'd1);
        nxt_prefix = (state == PREFIX) && !cur_last;
        nxt_tick   = cur_last ? 8'd0 : tick + 8'd1;
        cur        = tick_info(state == PREFIX, op_q, len_q, tick);
        nxt        = tick_info(nxt_prefix, op_q, len_q, nxt_tick);
        cur_tdi    = cur.shift & data_q[cur.sidx];
        nxt_tdi    = nxt.shift & data_q[nxt.sidx];
        len_bad    = cmd_op[1] && ((cmd_len == 5'd0) || (cmd_len > LEN_MAX));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            op_q      <= 2'b00;
            len_q     <= 5'd0;
            data_q    <= '0;
            cap       <= '0;
            tick      <= 8'd0;
            div       <= '0;
            starting  <= 1'b0;
            synced    <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (cmd_valid && cmd_ready) begin
                        op_q   <= cmd_op;
                        len_q  <= cmd_len;
                        data_q <= cmd_data;
                        cap    <= '0;
                        tick   <= 8'd0;
                        div    <= '0;
                        if (len_bad) begin
                            // Rejected without touching the TAP; ready never drops.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= DONE;
                        end else begin
                            cmd_ready <= 1'b0;
                            starting  <= 1'b1;
                            state     <= (!synced && cmd_op != OP_RESET) ? PREFIX : RUN;
                        end
                    end
                end
                default: begin
                    if (starting) begin
                        starting <= 1'b0;
                        TMS      <= cur.tms;
                        TDI      <= cur_tdi;
                    end else if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        if (!TCK) begin
                            TCK <= 1'b1;
                            if (cur.shift) cap[cur.sidx] <= TDO;
                        end else begin
                            TCK <= 1'b0;
                            if (!cur_last || state == PREFIX) begin
                                tick <= nxt_tick;
                                TMS  <= nxt.tms;
                                TDI  <= nxt_tdi;
                                if (cur_last) begin
                                    state  <= RUN;
                                    synced <= 1'b1;
                                end
                            end else begin
                                if (op_q == OP_RESET) synced <= 1'b1;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b0;
                                rsp_data  <= cap;
                                cmd_ready <= 1'b1;
                                state     <= DONE;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_master
// Description : Scoreboard bench for jtag_master with a behavioural TAP model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_master;

    localparam int IR_LEN  = 4;
    localparam int DR_MAX  = 16;
    localparam int CLK_DIV = 4;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_len = 5'd0;
    logic [15:0] cmd_data = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        TCK;
    logic        TMS;
    logic        TDI;
    logic        TDO = 1'b0;

    jtag_master #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .CLK_DIV(CLK_DIV)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tck_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural TAP (IEEE 1149.1 state graph) ----------------
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PADR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11,
                   EX1IR = 12, PAIR = 13, EX2IR = 14, UPIR = 15;

    int          tap = TLR;
    int          dcnt = 0;
    logic [15:0] dr_sr = 16'h0, dr_in = 16'h0, dr_upd = 16'h0, dr_cap = 16'h0;
    logic [3:0]  ir_sr = 4'h0, ir_in = 4'h0, ir_reg = 4'h0, ir_cap = 4'h0;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR:   return t ? TLR   : RTI;
            RTI:   return t ? SELDR : RTI;
            SELDR: return t ? SELIR : CAPDR;
            CAPDR: return t ? EX1DR : SHDR;
            SHDR:  return t ? EX1DR : SHDR;
            EX1DR: return t ? UPDR  : PADR;
            PADR:  return t ? EX2DR : PADR;
            EX2DR: return t ? UPDR  : SHDR;
            UPDR:  return t ? SELDR : RTI;
            SELIR: return t ? TLR   : CAPIR;
            CAPIR: return t ? EX1IR : SHIR;
            SHIR:  return t ? EX1IR : SHIR;
            EX1IR: return t ? UPIR  : PAIR;
            PAIR:  return t ? EX2IR : PAIR;
            EX2IR: return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge TCK) begin
        tck_cnt <= tck_cnt + 1;
        case (tap)
            CAPDR: begin dr_sr <= dr_cap; dcnt <= 0; end
            SHDR: begin
                dr_sr <= {1'b0, dr_sr[15:1]};
                dr_in <= {TDI, dr_in[15:1]};
                dcnt  <= dcnt + 1;
            end
            UPDR:  dr_upd <= dr_in >> (16 - dcnt);
            CAPIR: ir_sr <= ir_cap;
            SHIR: begin
                ir_sr <= {1'b0, ir_sr[3:1]};
                ir_in <= {TDI, ir_in[3:1]};
            end
            UPIR:  ir_reg <= ir_in;
            default: ;
        endcase
        tap <= tap_next(tap, TMS);
    end

    always @(negedge TCK)
        TDO <= (tap == SHDR) ? dr_sr[0] : (tap == SHIR) ? ir_sr[0] : 1'b0;

    // ---------------- expected pin stream, checked on every TCK rise ----------------
    logic [1:0] tq[$];
    logic [1:0] te;

    function automatic void push_tick(input logic tms, input logic tdi);
        tq.push_back({tms, tdi});
    endfunction

    function automatic void push_reset_walk();
        for (int i = 0; i < 6; i++) push_tick(i < 5, 1'b0);
    endfunction

    always @(posedge TCK) begin
        #1;
        if (tq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tck_edge: unexpected TCK rise (TMS=%0b TDI=%0b), expected none", TMS, TDI);
        end else begin
            te = tq.pop_front();
            chk("tms", 32'(TMS), 32'(te[1]));
            chk("tdi", 32'(TDI), 32'(te[0]));
        end
    end

    // ---------------- response scoreboard ----------------
    typedef struct {
        logic        err;
        logic [15:0] data;
        int          lat;
        int          ticks;
        int          kind;
        logic [15:0] val;
        int          acc;
        int          tck0;
    } exp_t;

    exp_t sq[$];
    exp_t mx;
    bit   synced_m = 1'b0;

    always @(negedge CLK) begin
        if (RST_N && rsp_valid) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp: unexpected rsp_valid (data=0x%0h err=%0b), expected none", rsp_data, rsp_err);
            end else begin
                mx = sq.pop_front();
                chk("rsp_err", 32'(rsp_err), 32'(mx.err));
                chk("rsp_data", 32'(rsp_data), 32'(mx.data));
                chk("latency", 32'(cyc - mx.acc), 32'(mx.lat));
                chk("tick_count", 32'(tck_cnt - mx.tck0), 32'(mx.ticks));
                chk("ready_at_rsp", 32'(cmd_ready), 32'd1);
                if (!mx.err) chk("tap_in_rti", 32'(tap), 32'(RTI));
                if (mx.kind == 1) chk("tap_ir", 32'(ir_reg), 32'(mx.val));
                if (mx.kind == 2) chk("tap_dr_update", 32'(dr_upd), 32'(mx.val));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [1:0] op, input logic [4:0] len, input logic [15:0] data,
                         input logic [15:0] dcap, input logic [3:0] icap);
        exp_t        x;
        int          n;
        int          guard;
        bit          bad;
        logic [15:0] mask;
        guard = 0;
        @(negedge CLK);
        while (!cmd_ready && guard < 4000) begin
            @(negedge CLK);
            guard++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready: still 0 after %0d cycles, expected 1", guard);
            return;
        end
        dr_cap = dcap;
        ir_cap = icap;
        bad    = op[1] && (len == 5'd0 || int'(len) > DR_MAX);
        mask   = 16'((32'h1 << len) - 32'h1);
        n      = 0;
        x.err  = bad;
        x.data = 16'h0;
        x.kind = 0;
        x.val  = 16'h0;
        x.acc  = cyc + 1;
        x.tck0 = tck_cnt;
        if (!bad) begin
            if (!synced_m && op != 2'b00) begin
                push_reset_walk();
                n += 6;
            end
            case (op)
                2'b00: begin push_reset_walk(); n += 6; end
                2'b01: begin
                    push_tick(1, 0); push_tick(1, 0); push_tick(0, 0); push_tick(0, 0);
                    for (int i = 0; i < IR_LEN; i++) push_tick(i == IR_LEN - 1, data[i]);
                    push_tick(1, 0); push_tick(0, 0);
                    n += IR_LEN + 6;
                    x.data = {12'h0, icap};
                    x.kind = 1;
                    x.val  = {12'h0, data[3:0]};
                end
                2'b10: begin
                    push_tick(1, 0); push_tick(0, 0); push_tick(0, 0);
                    for (int i = 0; i < int'(len); i++) push_tick(i == int'(len) - 1, data[i]);
                    push_tick(1, 0); push_tick(0, 0);
                    n += int'(len) + 5;
                    x.data = dcap & mask;
                    x.kind = 2;
                    x.val  = data & mask;
                end
                default: begin
                    for (int i = 0; i < int'(len); i++) push_tick(0, 0);
                    n += int'(len);
                end
            endcase
            synced_m = 1'b1;
            x.lat = 2 * n * CLK_DIV + 1;
        end else begin
            x.lat = 0;
        end
        x.ticks = n;
        sq.push_back(x);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sq.size() != 0) && guard < 5000) begin
            @(negedge CLK);
            guard++;
        end
        chk("responses_drained", 32'(sq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        logic [1:0] rop;
        logic [4:0] rlen;

        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("reset_tck", 32'(TCK), 32'd0);
        chk("reset_tms", 32'(TMS), 32'd1);
        chk("reset_tdi", 32'(TDI), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

        // IR load straight out of reset: reset prefix then IR=0110
        issue(2'b01, 5'd0, 16'h0006, 16'h0, 4'h9);
        drain();
        chk("ir_after_load", 32'(ir_reg), 32'h6);

        issue(2'b00, 5'd0, 16'h0, 16'h0, 4'h0);
        issue(2'b10, 5'd16, 16'h0086, 16'hA5C3, 4'h0);
        issue(2'b10, 5'd0, 16'hFFFF, 16'h0, 4'h0);
        issue(2'b11, 5'd17, 16'h0, 16'h0, 4'h0);
        issue(2'b11, 5'd2, 16'h0, 16'h0, 4'h0);

        // commands offered while busy must be ignored
        issue(2'b10, 5'd16, 16'h1234, 16'h5A5A, 4'h0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        for (int i = 0; i < 20; i++) @(negedge CLK);
        cmd_valid = 1'b0;
        drain();

        for (int k = 0; k < 40; k++) begin
            rop  = 2'($urandom_range(0, 3));
            rlen = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 16));
            issue(rop, rlen, 16'($urandom), 16'($urandom), 4'($urandom));
        end
        drain();

        // asynchronous reset during DR shift tick 5 (overall tick 8)
        issue(2'b10, 5'd16, 16'hBEEF, 16'h1357, 4'h0);
        base  = tck_cnt;
        guard = 0;
        while ((tck_cnt - base) < 9 && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        chk("reached_shift_tick5", 32'(tck_cnt - base), 32'd9);
        @(negedge CLK);
        RST_N = 1'b0;
        sq.delete();
        tq.delete();
        synced_m = 1'b0;
        #1;
        chk("midreset_tck", 32'(TCK), 32'd0);
        chk("midreset_tms", 32'(TMS), 32'd1);
        chk("midreset_tdi", 32'(TDI), 32'd0);
        chk("midreset_ready", 32'(cmd_ready), 32'd1);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // rejected command while unsynced must not mark the TAP as synced
        issue(2'b11, 5'd0, 16'h0, 16'h0, 4'h0);
        issue(2'b11, 5'd3, 16'h0, 16'h0, 4'h0);
        drain();
        chk("stream_drained", 32'(tq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
